// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq: sequential N x N matrix add / sub / multiply on W-bit
// unsigned elements, driven by a start/done handshake.
// Element-wise ops walk one element per cycle through a single adder.
// Multiply walks (i,j,k) with k innermost through one multiply-accumulate.
// Optional build macro: MATRIX_ALU_SAT_EN selects saturating arithmetic.
// When it is undefined, results wrap modulo 2^W.
module matrix_alu_seq #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [N*N*W-1:0] matrix_a,
    input  logic [N*N*W-1:0] matrix_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ovf,
    output logic [N*N*W-1:0] result
);
    localparam int NN = N * N;
    localparam int MW = NN * W;
    localparam int EW = $clog2(NN);
    localparam int CW = $clog2(N);
    localparam int AW = 2 * W + CW;
    localparam logic [EW-1:0] E_LAST = EW'(NN - 1);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN_EW, RUN_MM} state_t;

    state_t          state_q;
    logic [1:0]      op_q;
    logic [MW-1:0]   a_q, b_q, res_q;
    logic [EW-1:0]   e_q;
    logic [CW-1:0]   i_q, j_q, k_q;
    logic [AW-1:0]   acc_q, acc_d;
    logic            busy_q, done_q, err_q, ovf_q;

    logic            ew_sub;
    logic [W-1:0]    ew_a, ew_b, ew_val;
    logic [W:0]      ew_opnd, ew_sum;
    logic            ew_flag;
    logic [W-1:0]    mm_a, mm_b, mm_val;
    logic [2*W-1:0]  mm_prod;
    logic            mm_flag;

    // Operand selection plus the shared add/sub adder and the MAC datapath.
    always_comb begin
        ew_a    = a_q[MW-1 - int'(e_q)*W -: W];
        ew_b    = b_q[MW-1 - int'(e_q)*W -: W];
        ew_sub  = (op_q == 2'b01);
        // Subtraction as a + ~b + 1; bit W is carry on add, borrow on sub.
        ew_opnd = ew_sub ? ~{1'b0, ew_b} : {1'b0, ew_b};
        ew_sum  = {1'b0, ew_a} + ew_opnd + {{W{1'b0}}, ew_sub};
        ew_flag = ew_sum[W];
`ifdef MATRIX_ALU_SAT_EN
        ew_val  = ew_flag ? (ew_sub ? {W{1'b0}} : {W{1'b1}}) : ew_sum[W-1:0];
`else
        ew_val  = ew_sum[W-1:0];
`endif
        mm_a    = a_q[MW-1 - (int'(i_q)*N + int'(k_q))*W -: W];
        mm_b    = b_q[MW-1 - (int'(k_q)*N + int'(j_q))*W -: W];
        mm_prod = mm_a * mm_b;
        // Accumulator restarts at k=0 so no separate clear cycle is needed.
        acc_d   = ((k_q == '0) ? {AW{1'b0}} : acc_q) + {{(AW-2*W){1'b0}}, mm_prod};
        mm_flag = |acc_d[AW-1:W];
`ifdef MATRIX_ALU_SAT_EN
        mm_val  = mm_flag ? {W{1'b1}} : acc_d[W-1:0];
`else
        mm_val  = acc_d[W-1:0];
`endif
    end

    // Control FSM, iteration counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            e_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == 2'b11) begin
                            // Reserved op: report and leave result/ovf alone.
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            a_q     <= matrix_a;
                            b_q     <= matrix_b;
                            op_q    <= op;
                            ovf_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            e_q     <= '0;
                            i_q     <= '0;
                            j_q     <= '0;
                            k_q     <= '0;
                            state_q <= (op == 2'b10) ? RUN_MM : RUN_EW;
                        end
                    end
                end
                RUN_EW: begin
                    res_q[MW-1 - int'(e_q)*W -: W] <= ew_val;
                    if (ew_flag) ovf_q <= 1'b1;
                    if (e_q == E_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        e_q <= e_q + EW'(1);
                    end
                end
                RUN_MM: begin
                    acc_q <= acc_d;
                    if (k_q == C_LAST) begin
                        res_q[MW-1 - (int'(i_q)*N + int'(j_q))*W -: W] <= mm_val;
                        if (mm_flag) ovf_q <= 1'b1;
                        k_q <= '0;
                        if (j_q == C_LAST) begin
                            j_q <= '0;
                            if (i_q == C_LAST) begin
                                i_q     <= '0;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                i_q <= i_q + CW'(1);
                            end
                        end else begin
                            j_q <= j_q + CW'(1);
                        end
                    end else begin
                        k_q <= k_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign ovf    = ovf_q;
    assign result = res_q;

endmodule
